display_mux_ctrl: RTL and testbench



---
 rtl/display_mux_ctrl.sv | 110 +++++++++++
 tb/tb_display_mux_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_mux_ctrl.sv
// Digit-multiplexing scheduler for a single shared seven-segment decoder.
// Each digit slot begins with a blank interval (all anodes off) and then lights
// that digit's anode. The digit values are captured into a shadow copy once
// per frame, so a change on the inputs partway through a frame never appears
// on only some of the digits.
//
// state | meaning
// ------+-----------------------------------------------------------
// BLANK | start of a slot: all anodes off; hex_sel may change here
// ON    | anode of the current slot driven low; hex_sel held stable
module display_mux_ctrl #(
    parameter int N_DIGITS     = 2,
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 240,
    localparam int SLOT_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
    localparam int CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits_in,
    output logic [3:0]            hex_sel,
    output logic [N_DIGITS-1:0]   an,
    output logic [SLOT_W-1:0]     slot,
    output logic                  frame_start
);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SLOT_W-1:0]     slot_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [3:0]            hex_d;
    logic [N_DIGITS-1:0]   an_d;
    logic                  fs_d;

    // Next-state and registered-output values for the slot scheduler.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        slot_d   = slot;
        shadow_d = shadow_q;
        hex_d    = hex_sel;
        an_d     = an;
        fs_d     = 1'b0;

        if (!en) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            slot_d  = '0;
            an_d    = '1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ON;
                        an_d    = ~(AN_ONE << slot);
                    end
                end
                ST_ON: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        an_d    = '1;
                        slot_d  = (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
                        fs_d    = (slot == LAST_SLOT);
                        hex_d   = shadow_q[4*int'(slot_d) +: 4];
                    end
                end
                default: ;
            endcase
        end

        // Slot 0 blanking is the only window where a new frame's values are
        // taken; the decoder input for digit 0 comes straight from the capture.
        if (state_d == ST_BLANK && slot_d == '0) begin
            shadow_d = digits_in;
            hex_d    = digits_in[3:0];
        end
    end

    // State, counter, shadow and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            shadow_q    <= '0;
            slot        <= '0;
            hex_sel     <= '0;
            an          <= '1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            slot        <= slot_d;
            hex_sel     <= hex_d;
            an          <= an_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl: small 2-digit instance for sequencing,
// tearing, enable and async reset; 4-digit instance for exclusivity/boundaries.
module tb_display_mux_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, en;
    logic [7:0]  digits_in;
    logic [3:0]  hex_sel;
    logic [1:0]  an;
    logic [0:0]  slot;
    logic        frame_start;

    logic        reset2_n;
    logic [15:0] digits2;
    logic [3:0]  hex_sel2;
    logic [3:0]  an2;
    logic [1:0]  slot2;
    logic        frame_start2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_mux_ctrl #(.N_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .digits_in(digits_in),
        .hex_sel(hex_sel), .an(an), .slot(slot), .frame_start(frame_start)
    );

    display_mux_ctrl #(.N_DIGITS(4), .REFRESH_DIV(6), .BLANK_CYCLES(1)) dut4 (
        .clk(clk), .reset_n(reset2_n), .en(1'b1), .digits_in(digits2),
        .hex_sel(hex_sel2), .an(an2), .slot(slot2), .frame_start(frame_start2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance edge by edge until an matches v, bounded to 40 cycles.
    task automatic wait_an(input string tag, input logic [1:0] v);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (an == v) found = 1'b1;
        end
        chk(tag, found, 1'b1);
    endtask

    initial begin
        int q, s, c;
        logic [1:0] exp_an;
        logic [3:0] exp_lit;
        int onehot_err, len_err, seq_err, wraps, run_len;
        logic [1:0] prev_slot;
        logic first_change;

        reset_n   = 1'b0;
        reset2_n  = 1'b0;
        en        = 1'b1;
        digits_in = 8'h5A;
        digits2   = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_hex", hex_sel, 4'h0);
        chk("rst_an", an, 2'b11);
        chk("rst_slot", slot, 1'b0);
        chk("rst_fs", frame_start, 1'b0);

        reset_n  = 1'b1;
        reset2_n = 1'b1;
        // t counts edges since release: slot period 8 (2 blank + 6 lit), frame 16.
        for (int t = 1; t <= 48; t++) begin
            @(posedge clk);
            @(negedge clk);
            q = t % 16;
            s = q / 8;
            c = q % 8;
            exp_an = (c < 2) ? 2'b11 : ((s == 0) ? 2'b10 : 2'b01);
            chk($sformatf("seq_an_t%0d", t), an, exp_an);
            chk($sformatf("seq_slot_t%0d", t), slot, s);
            chk($sformatf("seq_hex_t%0d", t), hex_sel, (s == 0) ? 4'hA : 4'h5);
            chk($sformatf("seq_fs_t%0d", t), frame_start, (q == 0) ? 1'b1 : 1'b0);
        end

        // Mid-frame data change must not reach slot 1 of the current frame.
        wait_an("tear_wait_on0", 2'b10);
        digits_in = 8'h37;
        wait_an("tear_wait_on1", 2'b01);
        chk("tear_old_hi", hex_sel, 4'h5);
        wait_an("tear_wait_next0", 2'b10);
        chk("tear_new_lo", hex_sel, 4'h7);
        wait_an("tear_wait_next1", 2'b01);
        chk("tear_new_hi", hex_sel, 4'h3);

        // Drop enable during slot 1 lit.
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_off_an", an, 2'b11);
        chk("en_off_slot", slot, 1'b0);
        chk("en_off_hex", hex_sel, 4'h7);
        digits_in = 8'hC4;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("en_hold_an_%0d", i), an, 2'b11);
            chk($sformatf("en_hold_hex_%0d", i), hex_sel, 4'h4);
            chk($sformatf("en_hold_fs_%0d", i), frame_start, 1'b0);
        end
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_resume_an1", an, 2'b11);
        chk("en_resume_fs1", frame_start, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("en_resume_an2", an, 2'b10);
        chk("en_resume_hex", hex_sel, 4'h4);

        // Asynchronous reset while a digit is lit, checked before the next edge.
        #2 reset_n = 1'b0;
        #1;
        chk("arst_an", an, 2'b11);
        chk("arst_hex", hex_sel, 4'h0);
        chk("arst_slot", slot, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Four-digit instance: 1000 frames of 24 cycles with random data.
        onehot_err   = 0;
        len_err      = 0;
        seq_err      = 0;
        wraps        = 0;
        run_len      = 0;
        first_change = 1'b1;
        prev_slot    = slot2;
        for (int i = 0; i < 24000; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_start2) digits2 = 16'($urandom);
            exp_lit = ~(4'b0001 << slot2);
            if (an2 !== 4'b1111 && an2 !== exp_lit) onehot_err++;
            run_len++;
            if (slot2 != prev_slot) begin
                if (!first_change && run_len != 6) len_err++;
                if (slot2 != 2'(prev_slot + 2'd1)) seq_err++;
                if (prev_slot == 2'd3 && slot2 == 2'd0) wraps++;
                first_change = 1'b0;
                run_len = 0;
                prev_slot = slot2;
            end
        end
        chk("x4_onehot_errs", onehot_err, 0);
        chk("x4_slot_len_errs", len_err, 0);
        chk("x4_slot_seq_errs", seq_err, 0);
        chk("x4_wraps_ge_999", (wraps >= 999), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
